// File: rtl/core_ldst_multiple_seq.sv
// Load/store-multiple sequencer: expands a register list into word transfers over a
// valid/ready handshake, then pulses done with the base-register writeback value.
module core_ldst_multiple_seq #(
   parameter int unsigned NREGS      = 16,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WORD_BYTES = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [NREGS-1:0]          i_regs,
   input  logic [ADDR_W-1:0]         i_base,
   input  logic                      i_increment,
   input  logic                      i_pre_indexed,
   input  logic                      i_writeback,
   input  logic                      i_load,
   output logic                      o_busy,
   output logic                      o_xfer_valid,
   input  logic                      i_xfer_ready,
   output logic [$clog2(NREGS)-1:0]  o_xfer_reg,
   output logic [ADDR_W-1:0]         o_xfer_addr,
   output logic                      o_xfer_load,
   output logic                      o_xfer_last,
   output logic                      o_done,
   output logic                      o_wb_valid,
   output logic [ADDR_W-1:0]         o_wb_value
);

   localparam int unsigned IDX_W = $clog2(NREGS);
   localparam int unsigned CNT_W = $clog2(NREGS + 1);
   localparam int unsigned SHIFT = $clog2(WORD_BYTES);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   function automatic logic [IDX_W-1:0] f_lowest(input logic [NREGS-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(NREGS) - 1; i >= 0; i--) begin
         if (m[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CNT_W-1:0] f_popcount(input logic [NREGS-1:0] m);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(NREGS); i++) cnt = cnt + CNT_W'(m[i]);
      return cnt;
   endfunction

   state_e            r_state;
   logic [NREGS-1:0]  r_pending;
   logic              r_wb;
   logic              r_busy;
   logic              r_xfer_valid;
   logic [IDX_W-1:0]  r_xfer_reg;
   logic [ADDR_W-1:0] r_xfer_addr;
   logic              r_xfer_load;
   logic              r_xfer_last;
   logic              r_done;
   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_value;

   logic [CNT_W-1:0]  w_cnt;
   logic [ADDR_W-1:0] w_span;
   logic [ADDR_W-1:0] w_lo;
   logic [ADDR_W-1:0] w_wb_value;
   logic [NREGS-1:0]  w_pend_clr;
   logic              w_clr_last;

   always_comb begin
      w_cnt  = f_popcount(i_regs);
      w_span = ADDR_W'(w_cnt) << SHIFT;
      // Transfers always ascend from the lowest address, so only lo depends on the mode.
      case ({i_increment, i_pre_indexed})
         2'b10:   w_lo = i_base;
         2'b11:   w_lo = i_base + STRIDE;
         2'b01:   w_lo = i_base - w_span;
         default: w_lo = i_base - w_span + STRIDE;
      endcase
      w_wb_value = i_increment ? (i_base + w_span) : (i_base - w_span);
      w_pend_clr = r_pending & (r_pending - NREGS'(1));
      w_clr_last = (w_pend_clr != '0) && ((w_pend_clr & (w_pend_clr - NREGS'(1))) == '0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_pending    <= '0;
         r_wb         <= 1'b0;
         r_busy       <= 1'b0;
         r_xfer_valid <= 1'b0;
         r_xfer_reg   <= '0;
         r_xfer_addr  <= '0;
         r_xfer_load  <= 1'b0;
         r_xfer_last  <= 1'b0;
         r_done       <= 1'b0;
         r_wb_valid   <= 1'b0;
         r_wb_value   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_pending    <= i_regs;
                  r_wb         <= i_writeback;
                  r_busy       <= 1'b1;
                  r_xfer_load  <= i_load;
                  r_xfer_reg   <= f_lowest(i_regs);
                  r_xfer_addr  <= w_lo;
                  r_xfer_last  <= (w_cnt == CNT_W'(1));
                  r_wb_value   <= w_wb_value;
                  r_xfer_valid <= (w_cnt != '0);
                  r_done       <= (w_cnt == '0);
                  r_wb_valid   <= (w_cnt == '0) && i_writeback;
                  r_state      <= (w_cnt != '0) ? StXfer : StDone;
               end
            end
            StXfer: begin
               if (i_xfer_ready) begin
                  r_pending   <= w_pend_clr;
                  r_xfer_addr <= r_xfer_addr + STRIDE;
                  if (r_xfer_last) begin
                     r_state      <= StDone;
                     r_xfer_valid <= 1'b0;
                     r_xfer_last  <= 1'b0;
                     r_done       <= 1'b1;
                     r_wb_valid   <= r_wb;
                  end else begin
                     r_xfer_reg  <= f_lowest(w_pend_clr);
                     r_xfer_last <= w_clr_last;
                  end
               end
            end
            StDone: begin
               r_state    <= StIdle;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_wb_valid <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_xfer_valid = r_xfer_valid;
   assign o_xfer_reg   = r_xfer_reg;
   assign o_xfer_addr  = r_xfer_addr;
   assign o_xfer_load  = r_xfer_load;
   assign o_xfer_last  = r_xfer_last;
   assign o_done       = r_done;
   assign o_wb_valid   = r_wb_valid;
   assign o_wb_value   = r_wb_value;

endmodule

// File: tb/tb_core_ldst_multiple_seq.sv
// Directed bench for core_ldst_multiple_seq with hand-computed transfer sequences.
module tb_core_ldst_multiple_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] regs;
   logic [31:0] base;
   logic        increment, pre_indexed, writeback, load;
   logic        busy, xfer_valid, xfer_ready, xfer_load, xfer_last, done, wb_valid;
   logic [3:0]  xfer_reg;
   logic [31:0] xfer_addr, wb_value;

   int n_cmp = 0;
   int n_err = 0;

   core_ldst_multiple_seq #(.NREGS(16), .ADDR_W(32), .WORD_BYTES(4)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_regs        (regs),
      .i_base        (base),
      .i_increment   (increment),
      .i_pre_indexed (pre_indexed),
      .i_writeback   (writeback),
      .i_load        (load),
      .o_busy        (busy),
      .o_xfer_valid  (xfer_valid),
      .i_xfer_ready  (xfer_ready),
      .o_xfer_reg    (xfer_reg),
      .o_xfer_addr   (xfer_addr),
      .o_xfer_load   (xfer_load),
      .o_xfer_last   (xfer_last),
      .o_done        (done),
      .o_wb_valid    (wb_valid),
      .o_wb_value    (wb_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Drive a start for one cycle, then scramble the sampled inputs to prove they are latched.
   task automatic launch(input logic [15:0] r, input logic [31:0] b, input logic inc,
                         input logic pre, input logic wb, input logic ld);
      regs = r; base = b; increment = inc; pre_indexed = pre; writeback = wb; load = ld;
      start = 1'b1;
      step();
      start = 1'b0;
      regs = 16'hA5A5; base = 32'hDEAD_BEEF; increment = ~inc; pre_indexed = ~pre;
      writeback = ~wb; load = ~ld;
   endtask

   task automatic exp_xfer(input string tag, input int r, input logic [31:0] a,
                           input logic last);
      check({tag, ".valid"}, 64'(xfer_valid), 64'(1'b1));
      check({tag, ".reg"},   64'(xfer_reg),   64'(r));
      check({tag, ".addr"},  64'(xfer_addr),  64'(a));
      check({tag, ".last"},  64'(xfer_last),  64'(last));
      check({tag, ".busy"},  64'(busy),       64'(1'b1));
   endtask

   task automatic exp_done(input string tag, input logic wbv, input logic [31:0] wbval);
      check({tag, ".done"},     64'(done),       64'(1'b1));
      check({tag, ".wb_valid"}, 64'(wb_valid),   64'(wbv));
      check({tag, ".wb_value"}, 64'(wb_value),   64'(wbval));
      check({tag, ".valid"},    64'(xfer_valid), 64'(1'b0));
      check({tag, ".busy"},     64'(busy),       64'(1'b1));
   endtask

   task automatic exp_idle(input string tag);
      check({tag, ".busy"},  64'(busy),       64'(1'b0));
      check({tag, ".done"},  64'(done),       64'(1'b0));
      check({tag, ".valid"}, 64'(xfer_valid), 64'(1'b0));
   endtask

   task automatic exp_reset(input string tag);
      check({tag, ".all"}, {53'(0), busy, xfer_valid, xfer_last, done, wb_valid, xfer_load,
                            xfer_reg, 1'b0}, 64'(0));
      check({tag, ".addr"},  64'(xfer_addr), 64'(0));
      check({tag, ".wbval"}, 64'(wb_value),  64'(0));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; regs = '0; base = '0; increment = 1'b0;
      pre_indexed = 1'b0; writeback = 1'b0; load = 1'b0; xfer_ready = 1'b1;
      step(); step();
      exp_reset("reset");
      rst_n = 1'b1;
      step();

      // Increment-after
      launch(16'h000B, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_xfer("ia0", 0, 32'h1000, 1'b0);
      check("ia0.load", 64'(xfer_load), 64'(1'b1));
      step(); exp_xfer("ia1", 1, 32'h1004, 1'b0);
      step(); exp_xfer("ia2", 3, 32'h1008, 1'b1);
      step(); exp_done("ia.done", 1'b1, 32'h100C);
      step(); exp_idle("ia.idle");

      // Decrement-before, store
      launch(16'h8001, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_xfer("db0", 0, 32'h1FF8, 1'b0);
      check("db0.load", 64'(xfer_load), 64'(1'b0));
      step(); exp_xfer("db1", 15, 32'h1FFC, 1'b1);
      step(); exp_done("db.done", 1'b1, 32'h1FF8);
      step(); exp_idle("db.idle");

      // Increment-before under back-pressure, W=0; a start during the stall is ignored
      xfer_ready = 1'b0;
      launch(16'h0006, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         exp_xfer($sformatf("bp.hold%0d", k), 1, 32'h14, 1'b0);
         if (k == 1) begin
            regs = 16'h0001; base = 32'h0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      exp_xfer("bp.hold3", 1, 32'h14, 1'b0);
      xfer_ready = 1'b1;
      step(); exp_xfer("bp1", 2, 32'h18, 1'b1);
      step(); exp_done("bp.done", 1'b0, 32'h18);
      step(); exp_idle("bp.idle");

      // Empty list, with a start attempt during the done cycle
      launch(16'h0000, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_done("empty.done", 1'b1, 32'h40);
      regs = 16'h0001; start = 1'b1;
      step();
      start = 1'b0;
      exp_idle("empty.idle");

      // Wrap-around; launched in the cycle right after a done cycle
      launch(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_xfer("wrap0", 0, 32'hFFFF_FFFC, 1'b0);
      step(); exp_xfer("wrap1", 1, 32'h0000_0000, 1'b1);
      step(); exp_done("wrap.done", 1'b1, 32'h4);
      step(); exp_idle("wrap.idle");

      // Asynchronous reset mid-sequence after one handshake
      launch(16'h000F, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_xfer("rst0", 0, 32'h100, 1'b0);
      step(); exp_xfer("rst1", 1, 32'h104, 1'b0);
      #2 rst_n = 1'b0;
      #1 exp_reset("rst.async");
      step();
      exp_reset("rst.held");
      rst_n = 1'b1;
      step();
      exp_idle("rst.after");
      launch(16'h0012, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_xfer("post0", 1, 32'h200, 1'b0);
      step(); exp_xfer("post1", 4, 32'h204, 1'b1);
      step(); exp_done("post.done", 1'b1, 32'h208);
      step(); exp_idle("post.idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/core_ldst_multiple_seq.md
Name: core_ldst_multiple_seq

Overview:
- Sequences one load/store-multiple instruction into individual word transfers.
- Accepts a decoded register list, a base address and the addressing-mode bits.
- Emits one register index and address per transfer over a valid/ready handshake to the memory stage, then reports the base-register writeback value.
- Sits between the decode stage and the load/store unit. It generalises the fixed 16-register LDM/STM decode to a parametrised register count, address width and word size.

Parameters:
NREGS, 16, number of bits in the register list (power of two, 2..32)
ADDR_W, 32, address width in bits
WORD_BYTES, 4, byte stride per transfer (power of two)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; accepted only when busy=0
regs  input  NREGS  register list; bit i set means register i is transferred
base  input  ADDR_W  value of the base register Rn
increment  input  1  1 = addresses ascend from base (U bit), 0 = descend
pre_indexed  input  1  1 = step before the first access (P bit)
writeback  input  1  W bit
load  input  1  1 = load, 0 = store; passed through on xfer_load
busy  output  1  sequence in progress; high from the cycle after an accepted start through the done cycle
xfer_valid  output  1  a transfer is presented
xfer_ready  input  1  the memory stage accepts the transfer
xfer_reg  output  $clog2(NREGS)  register index of the current transfer
xfer_addr  output  ADDR_W  word address of the current transfer
xfer_load  output  1  latched load bit
xfer_last  output  1  the current transfer is the final one
done  output  1  one-cycle pulse when the sequence completes
wb_valid  output  1  qualified by done; equals the latched writeback bit
wb_value  output  ADDR_W  new base value; valid only while done=1

Behaviour:
- Reset values, async on rst_n low: state IDLE; busy, xfer_valid, xfer_last, done, wb_valid, xfer_load all 0; xfer_reg, xfer_addr, wb_value 0.
- Reset mid-sequence aborts to IDLE with no done pulse.
- States: IDLE, XFER, DONE.
- Start acceptance, IDLE with start=1:
  - Latch regs into a pending mask, plus load, writeback and increment.
  - n = popcount(regs), held in $clog2(NREGS+1) bits.
  - Compute lowest address lo (all arithmetic modulo 2^ADDR_W, S = WORD_BYTES):
    - increment-after: lo = base
    - increment-before: lo = base + S
    - decrement-after: lo = base - n*S + S
    - decrement-before: lo = base - n*S
  - Compute wb_value: base + n*S if increment, else base - n*S.
  - Next state: XFER if n>0, else DONE (empty list: zero transfers, wb_value = base).
- XFER:
  - xfer_valid=1.
  - xfer_reg = index of the lowest set bit in the pending mask.
  - xfer_addr = current address, initialised to lo.
  - xfer_last = exactly one bit remains set in the pending mask.
  - Registers always go lowest-numbered first to the lowest address, for both directions.
  - On xfer_valid && xfer_ready: clear that bit and advance the address by +S. If xfer_last, go to DONE.
  - Without xfer_ready, all xfer_* outputs hold stable.
  - Throughput: one transfer per cycle when xfer_ready is held high.
- DONE:
  - done=1 and wb_valid = latched writeback for exactly one cycle; then IDLE.
  - busy drops in the following cycle.
- start while busy=1 is ignored. start in the cycle after DONE (state IDLE) is accepted.
- Latency:
  - start to first xfer_valid: 1 cycle.
  - Last handshake to done: 1 cycle.
  - Empty list: done 1 cycle after start.
- Inputs other than start are sampled only at acceptance. Later changes have no effect.
- No internal restriction on which registers appear in the list (including register NREGS-1). Privileged and SPSR handling belongs to the consumer.

Test Plan:
- Increment-after, NREGS=16, regs=16'h000B, base=32'h1000, W=1, xfer_ready=1 -> transfers (r0,0x1000),(r1,0x1004),(r3,0x1008); xfer_last on the third; done next cycle with wb_valid=1, wb_value=0x100C.
- Decrement-before, regs=16'h8001, base=32'h2000, W=1 -> (r0,0x1FF8),(r15,0x1FFC); wb_value=0x1FF8.
- Back-pressure: regs=16'h0006, increment-before, base=0x10, xfer_ready low 3 cycles then high -> (r1,0x14) held stable for 4 cycles, then (r2,0x18); done follows.
- Empty list with W=1, base=0x40 -> no xfer_valid; done 1 cycle after start; wb_value=0x40. start during busy is ignored; busy stays consistent.
- Wrap-around: increment-after, base=32'hFFFFFFFC, regs=16'h0003 -> addresses 0xFFFFFFFC, 0x00000000; wb_value=0x00000004.
- Async reset asserted mid-XFER after one handshake -> all outputs 0 immediately, no done; a fresh start then runs a full sequence correctly.
